mem_access_ctrl: RTL and testbench

- MEM-stage initiator that drives the word-addressed data memory: address, write data, write enable and read enable.
- Accepts one load/store request from the pipeline and performs byte/halfword/word accesses, using read-modify-write for sub-word stores.
- Returns sign/zero-extended load data with a one-cycle response pulse.
- Holds the pipeline through req_ready while busy.

---
 rtl/mem_access_ctrl_pkg.sv | 19 +
 rtl/mem_access_ctrl_if.sv | 19 +
 rtl/mem_access_ctrl_lane_align.sv | 21 ++
 rtl/mem_access_ctrl.sv | 86 ++++++++
 tb/tb_mem_access_ctrl.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// mem_ctrl_pkg: size encodings, controller states and lane helpers for mem_access_ctrl
package mem_ctrl_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [31:0] LANE_BYTE = 32'h0000_00ff;
  localparam logic [31:0] LANE_HALF = 32'h0000_ffff;
  localparam logic [31:0] LANE_WORD = 32'hffff_ffff;
  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return s == 2'b11 ? SIZE_WORD : s;
  endfunction
  function automatic logic misaligned(input logic [1:0] s, input logic [1:0] off);
    return (s == SIZE_HALF && off[0]) || (s == SIZE_WORD && off != 2'b00);
  endfunction
  function automatic logic [1:0] align_off(input logic [1:0] s, input logic [1:0] off);
    return s == SIZE_BYTE ? off : s == SIZE_HALF ? {off[1], 1'b0} : 2'b00;
  endfunction
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: pipeline request/response and data-memory bus of mem_access_ctrl
interface mem_access_ctrl_if #(parameter int ADDR_W = 11);
  logic req_valid, req_ready, req_we, req_unsigned;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata;
  logic resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0] mem_in_data, mem_out_data;
  logic mem_write, mem_read;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_out_data,
    input req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_in_data, mem_write, mem_read
  );
  modport slave (
    input req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_out_data,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_in_data, mem_write, mem_read
  );
endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// mem_lane_align: big-endian lane extract/extend for loads and lane merge for sub-word stores
module mem_lane_align import mem_ctrl_pkg::*; (
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);
  logic [4:0]  sh;
  logic [31:0] mask, lane;
  always_comb begin
    sh = size == SIZE_BYTE ? {~off, 3'b000} : size == SIZE_HALF ? {~off[1], 4'b0000} : 5'd0;
    mask = size == SIZE_BYTE ? LANE_BYTE : size == SIZE_HALF ? LANE_HALF : LANE_WORD;
    lane = (word >> sh) & mask;
    ldata = size == SIZE_BYTE ? {{24{~uns & lane[7]}}, lane[7:0]}
          : size == SIZE_HALF ? {{16{~uns & lane[15]}}, lane[15:0]} : word;
    mdata = (word & ~(mask << sh)) | ((wdata & mask) << sh);
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store initiator with read-modify-write sub-word stores.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module mem_access_ctrl import mem_ctrl_pkg::*; #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input logic clock,
  input logic reset_n,
  mem_access_ctrl_if.slave bus
);
  state_t state;
  logic we_q, uns_q, a_trap, a_sw;
  logic [1:0] size_q, off_q, a_size, a_off;
  logic [DATA_W-1:0] wdata_q, ldata, mdata;
  always_comb begin
    a_size = norm_size(bus.req_size);
`ifdef MEM_MISALIGN_TRAP_EN
    a_off = bus.req_addr[1:0];
    a_trap = misaligned(a_size, a_off);
`else
    a_off = align_off(a_size, bus.req_addr[1:0]);
    a_trap = 1'b0;
`endif
    a_sw = bus.req_we && a_size == SIZE_WORD;
  end
  assign bus.req_ready = state == IDLE;
  assign bus.resp_valid = state == RESP;
  mem_lane_align u_align (
    .word(bus.mem_out_data), .off(off_q), .size(size_q), .uns(uns_q),
    .wdata(wdata_q), .ldata(ldata), .mdata(mdata)
  );
  // full-word stores write straight from IDLE; sub-word stores read first, then write the merge
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= SIZE_BYTE;
      off_q <= 2'b00;
      wdata_q <= '0;
      bus.resp_err <= 1'b0;
      bus.resp_rdata <= '0;
      bus.mem_address <= '0;
      bus.mem_in_data <= '0;
      bus.mem_write <= 1'b0;
      bus.mem_read <= 1'b0;
    end else
      case (state)
        IDLE: if (bus.req_valid) begin
          we_q <= bus.req_we;
          uns_q <= bus.req_unsigned;
          size_q <= a_size;
          off_q <= a_off;
          wdata_q <= bus.req_wdata;
          bus.mem_address <= bus.req_addr[ADDR_W+1:2];
          bus.resp_err <= a_trap;
          if (a_trap) begin
            bus.resp_rdata <= '0;
            state <= RESP;
          end else begin
            bus.mem_write <= a_sw;
            bus.mem_read <= !a_sw;
            if (a_sw) bus.mem_in_data <= bus.req_wdata;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          bus.mem_read <= 1'b0;
          if (we_q && size_q != SIZE_WORD) begin
            bus.mem_in_data <= mdata;
            bus.mem_write <= 1'b1;
            state <= MERGE_WR;
          end else begin
            bus.mem_write <= 1'b0;
            bus.resp_rdata <= we_q ? '0 : ldata;
            state <= RESP;
          end
        end
        MERGE_WR: begin
          bus.mem_write <= 1'b0;
          bus.resp_rdata <= '0;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed self-checking bench for mem_access_ctrl with a behavioural word memory
module tb_mem_access_ctrl;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int tot = 0;
  int bad = 0;
  logic [31:0] r_data;
  logic r_err;
  int r_lat, r_rd, r_wr, seen;
  logic [31:0] mem [0:2047];
  mem_access_ctrl_if #(.ADDR_W(11)) bus ();
  mem_access_ctrl #(.ADDR_W(11), .DATA_W(32)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  always @(posedge clock) if (bus.mem_write) mem[bus.mem_address] <= bus.mem_in_data;
  always @(negedge clock) if (bus.mem_read) bus.mem_out_data <= mem[bus.mem_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clock);
    chk("ready_before_req", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_size = sz;
    bus.req_unsigned = uns;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    r_lat = 1;
    r_rd = 0;
    r_wr = 0;
    while (!bus.resp_valid && r_lat < 10) begin
      r_rd += int'(bus.mem_read);
      r_wr += int'(bus.mem_write);
      @(posedge clock);
      #1 r_lat++;
    end
    r_data = bus.resp_rdata;
    r_err = bus.resp_err;
    @(posedge clock);
    #1 chk("resp_one_cycle", {31'b0, bus.resp_valid}, 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    #12;
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_addr", {21'b0, bus.mem_address}, 32'd0);
    chk("rst_in_data", bus.mem_in_data, 32'd0);
    chk("rst_we_re", {30'b0, bus.mem_write, bus.mem_read}, 32'd0);
    @(negedge clock) reset_n = 1'b1;
    req(1'b1, 2'b10, 1'b0, 32'h4, 32'h1122_3344);
    chk("sw_lat", r_lat, 2);
    chk("sw_wr_cycles", r_wr, 1);
    chk("sw_rd_cycles", r_rd, 0);
    chk("sw_rdata", r_data, 32'd0);
    req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    chk("lw_data", r_data, 32'h1122_3344);
    chk("lw_lat", r_lat, 2);
    chk("lw_rd_cycles", r_rd, 1);
    chk("lw_wr_cycles", r_wr, 0);
    req(1'b1, 2'b11, 1'b0, 32'h4, 32'h80FF_7F01);
    chk("sw_size11_mem", mem[1], 32'h80FF_7F01);
    req(1'b0, 2'b00, 1'b0, 32'h4, 32'h0);
    chk("lb_4", r_data, 32'hFFFF_FF80);
    req(1'b0, 2'b00, 1'b1, 32'h4, 32'h0);
    chk("lbu_4", r_data, 32'h0000_0080);
    req(1'b0, 2'b01, 1'b0, 32'h6, 32'h0);
    chk("lh_6", r_data, 32'h0000_7F01);
    req(1'b0, 2'b01, 1'b0, 32'h4, 32'h0);
    chk("lh_4", r_data, 32'hFFFF_80FF);
    req(1'b0, 2'b01, 1'b1, 32'h4, 32'h0);
    chk("lhu_4", r_data, 32'h0000_80FF);
    req(1'b0, 2'b00, 1'b0, 32'h7, 32'h0);
    chk("lb_7", r_data, 32'h0000_0001);
    req(1'b1, 2'b10, 1'b0, 32'h8, 32'hAABB_CCDD);
    req(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_0012);
    chk("sb_9_mem", mem[2], 32'hAA12_CCDD);
    chk("sb_lat", r_lat, 3);
    chk("sb_rd_cycles", r_rd, 1);
    chk("sb_wr_cycles", r_wr, 1);
    chk("sb_rdata", r_data, 32'd0);
    req(1'b1, 2'b01, 1'b0, 32'hA, 32'h0000_3456);
    chk("sh_a_mem", mem[2], 32'hAA12_3456);
    chk("sh_lat", r_lat, 3);
    req(1'b1, 2'b10, 1'b0, 32'h1FFC, 32'hDEAD_BEEF);
    chk("sw_top_mem", mem[2047], 32'hDEAD_BEEF);
    req(1'b0, 2'b10, 1'b0, 32'h3FFC, 32'h0);
    chk("lw_wrap", r_data, 32'hDEAD_BEEF);
    req(1'b0, 2'b10, 1'b0, 32'h5, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_err", {31'b0, r_err}, 32'd1);
    chk("mis_rdata", r_data, 32'd0);
    chk("mis_lat", r_lat, 1);
    chk("mis_mem_cycles", r_rd + r_wr, 0);
`else
    chk("mis_err", {31'b0, r_err}, 32'd0);
    chk("mis_rdata", r_data, 32'h80FF_7F01);
    chk("mis_lat", r_lat, 2);
`endif
    req(1'b1, 2'b10, 1'b0, 32'h0, 32'h0102_0304);
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_size = 2'b00;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0000_00AB;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    @(posedge clock);
    #1 chk("merge_we_high", {31'b0, bus.mem_write}, 32'd1);
    reset_n = 1'b0;
    #1 chk("rst_we_drop", {31'b0, bus.mem_write}, 32'd0);
    seen = int'(bus.resp_valid);
    @(posedge clock);
    #1 chk("rst_word_kept", mem[0], 32'h0102_0304);
    @(negedge clock) reset_n = 1'b1;
    chk("rst_ready_after", {31'b0, bus.req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      seen += int'(bus.resp_valid);
    end
    chk("rst_no_resp", seen, 0);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
